wb_fifo_target: RTL and testbench
=================================

Name: wb_fifo_target

Overview:
Wishbone target (responder) providing a register-mapped mailbox: CPU-side writes push a TX FIFO drained by a valid/ready stream, and CPU-side reads pop an RX FIFO filled by a valid/ready stream. It sits behind the initiator port of a clock-domain bridge, or directly on a fabric, in the i_clock domain. It is single-clock and issues one registered ack per transfer.

Parameters:
ADR_WIDTH, 32, Wishbone address width; only adr[3:2] decoded.
DAT_WIDTH, 32, Wishbone and stream data width.
DEPTH, 8, entries per FIFO; power of two, 2..128.

Ports:
i_clock  input  1  clock.
reset  input  1  asynchronous, active-high reset.
i_adr  input  ADR_WIDTH  Wishbone address.
i_dat_w  input  DAT_WIDTH  write data.
i_dat_r  output  DAT_WIDTH  read data.
i_cyc  input  1  bus cycle.
i_stb  input  1  strobe.
i_ack  output  1  acknowledge.
i_we  input  1  write enable.
i_sel  input  DAT_WIDTH/8  byte select; ignored, all accesses are full-word.
o_tx_valid  output  1  TX FIFO non-empty.
o_tx_data  output  DAT_WIDTH  TX FIFO head, show-ahead.
i_tx_ready  input  1  TX consumer ready.
i_rx_valid  input  1  RX producer valid.
i_rx_data  input  DAT_WIDTH  RX word.
o_rx_ready  output  1  RX FIFO not full.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock i_clock.
- On reset, asynchronously: i_ack=0, i_dat_r=0, both FIFOs empty, o_tx_valid=0, o_rx_ready=1, overflow flag=0, FSM=IDLE.
- FSM IDLE/ACK.
  - IDLE: if i_cyc&i_stb, perform the access this edge, register i_dat_r, go to ACK.
  - ACK: i_ack=1 for exactly one cycle, then return to IDLE unconditionally.
  - Latency: ack arrives 1 cycle after the strobe is sampled; one transfer per 2 cycles minimum.
  - A strobe still high in the IDLE cycle after ACK is a new transfer. Masters must drop stb after ack if they do not want one.
- Register map, word offsets:
  - 0x0 TXDATA
    - Write: pushes i_dat_w if TX is not full; otherwise the word is dropped and the sticky overflow flag is set.
    - Read: returns 0.
  - 0x4 RXDATA
    - Read: returns the RX head and pops it; if RX is empty, returns 0 with no pop.
    - Write: ignored.
  - 0x8 STATUS, read-only:
    - [7:0] tx_count
    - [15:8] rx_count
    - [16] tx_full
    - [17] rx_empty
    - [24] tx_overflow
    - all other bits 0
    - Writes ignored.
  - 0xC CTRL, write:
    - bit0 clears TX FIFO
    - bit1 clears RX FIFO
    - bit2 clears overflow
    - Read returns 0.
- Counts are $clog2(DEPTH)+1 bits, zero-extended to 8 bits. A value equal to DEPTH means full.
- Stream handshake: a transfer occurs on o_tx_valid&i_tx_ready and on i_rx_valid&o_rx_ready. Data is held stable while valid and not ready.
- Full/empty are evaluated from registered counts at the start of the cycle:
  - A push to a full FIFO is dropped even if a pop happens in the same cycle.
  - A pop from an empty FIFO is a no-op.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur and the count is unchanged.
- A clear has priority over a same-cycle push or pop: the FIFO ends empty and any word accepted that cycle is discarded.
- Pointers wrap modulo DEPTH.
- A reset asserted mid-transfer aborts the transfer and no ack is issued.

Decomposition:
- Package wb_fifo_target_pkg: register offsets (TXDATA=0, RXDATA=1, STATUS=2, CTRL=3 as adr[3:2]), STATUS bit positions, CTRL bit positions.
- Sub-module fw_sync_fifo #(WIDTH, DEPTH): synchronous show-ahead FIFO with push, pop, clear (priority), full, empty, and count. Instantiated twice.

Test Plan:
1. Write 0xDEADBEEF to 0x0 with i_tx_ready=1 -> i_ack on the cycle after the strobe; o_tx_valid=1 and o_tx_data=0xDEADBEEF on the following cycle; tx_count returns to 0.
2. Write 9 words with i_tx_ready=0 and DEPTH=8 -> STATUS reads tx_count=8, tx_full=1, overflow=1 (0x0101_0008 with RX empty, rx_empty at bit 17 → 0x0103_0008). Then write CTRL=0x4 -> overflow clears.
3. Push RX words 0x11 and 0x22 via the stream, then read 0x4 twice, then a third time -> reads return 0x11, 0x22, then 0; the third read leaves rx_count=0.
4. Push and pop TX in the same cycle with count=3 -> count stays 3 and the head advances. Repeat with count=8 and the push is dropped, leaving count=7.
5. CTRL=0x3 write in the same cycle as an i_rx_valid push -> both FIFOs are empty afterwards; rx_count=0 and tx_count=0.
6. Assert reset during the ACK cycle -> i_ack=0 immediately, FIFOs empty, o_rx_ready=1; the next strobe after release is acked normally.

Source files
------------

// File: rtl/wb_fifo_target_pkg.sv
// Shared constants for the Wishbone mailbox target:
// register offsets (adr[3:2]) and STATUS/CTRL bit positions.
package wb_fifo_target_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_CNT  = 0;
  localparam int ST_RX_CNT  = 8;
  localparam int ST_TX_FULL = 16;
  localparam int ST_RX_EMPT = 17;
  localparam int ST_TX_OVF  = 24;

  localparam int CTRL_CLR_TX  = 0;
  localparam int CTRL_CLR_RX  = 1;
  localparam int CTRL_CLR_OVF = 2;

endpackage

// File: rtl/fw_sync_fifo.sv
// Single-clock show-ahead FIFO; clear wins over push/pop,
// full/empty come from the registered count.
module fw_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   i_clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign head    = mem[rptr];

  always_ff @(posedge i_clock) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_fifo_target.sv
// Wishbone mailbox target: bus writes feed the TX stream,
// bus reads drain the RX stream; one registered ack per transfer.
module wb_fifo_target
  import wb_fifo_target_pkg::*;
#(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int DEPTH     = 8
) (
  input  logic                   i_clock,
  input  logic                   reset,
  input  logic [ADR_WIDTH-1:0]   i_adr,
  input  logic [DAT_WIDTH-1:0]   i_dat_w,
  output logic [DAT_WIDTH-1:0]   i_dat_r,
  input  logic                   i_cyc,
  input  logic                   i_stb,
  output logic                   i_ack,
  input  logic                   i_we,
  input  logic [DAT_WIDTH/8-1:0] i_sel,
  output logic                   o_tx_valid,
  output logic [DAT_WIDTH-1:0]   o_tx_data,
  input  logic                   i_tx_ready,
  input  logic                   i_rx_valid,
  input  logic [DAT_WIDTH-1:0]   i_rx_data,
  output logic                   o_rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]           state;
  logic                 overflow;
  logic [1:0]           off;
  logic                 access;
  logic                 wr;
  logic                 rd;
  logic                 tx_push;
  logic                 tx_clear;
  logic                 rx_pop;
  logic                 rx_clear;
  logic                 ovf_clear;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 rx_full;
  logic                 rx_empty;
  logic [CW-1:0]        tx_count;
  logic [CW-1:0]        rx_count;
  logic [DAT_WIDTH-1:0] rx_head;
  logic [DAT_WIDTH-1:0] status;
  logic [DAT_WIDTH-1:0] rd_data;
  logic                 unused_bits;

  assign unused_bits = ^{i_sel, i_adr[ADR_WIDTH-1:4], i_adr[1:0]};

  assign off    = i_adr[3:2];
  assign access = (state == ST_IDLE) & i_cyc & i_stb;
  assign wr     = access & i_we;
  assign rd     = access & ~i_we;

  assign tx_push   = wr & (off == REG_TXDATA);
  assign rx_pop    = rd & (off == REG_RXDATA);
  assign tx_clear  = wr & (off == REG_CTRL) & i_dat_w[CTRL_CLR_TX];
  assign rx_clear  = wr & (off == REG_CTRL) & i_dat_w[CTRL_CLR_RX];
  assign ovf_clear = wr & (off == REG_CTRL) & i_dat_w[CTRL_CLR_OVF];

  assign o_tx_valid = ~tx_empty;
  assign o_rx_ready = ~rx_full;
  assign i_ack      = (state == ST_ACK);

  fw_sync_fifo #(.WIDTH(DAT_WIDTH), .DEPTH(DEPTH)) u_tx (
    .i_clock   (i_clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (i_dat_w),
    .pop       (i_tx_ready),
    .clear     (tx_clear),
    .head      (o_tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  fw_sync_fifo #(.WIDTH(DAT_WIDTH), .DEPTH(DEPTH)) u_rx (
    .i_clock   (i_clock),
    .reset     (reset),
    .push      (i_rx_valid),
    .push_data (i_rx_data),
    .pop       (rx_pop),
    .clear     (rx_clear),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  always_comb begin
    status = '0;
    status[ST_TX_CNT +: 8] = 8'(tx_count);
    status[ST_RX_CNT +: 8] = 8'(rx_count);
    status[ST_TX_FULL]     = tx_full;
    status[ST_RX_EMPT]     = rx_empty;
    status[ST_TX_OVF]      = overflow;
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      (off == REG_RXDATA): rd_data = rx_empty ? '0 : rx_head;
      (off == REG_STATUS): rd_data = status;
      default:             rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      i_dat_r  <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (access) state <= ST_ACK;
        default: state <= ST_IDLE;
      endcase
      if (access) i_dat_r <= rd ? rd_data : '0;
      // full is judged before any same-cycle TX pop
      if (ovf_clear)              overflow <= 1'b0;
      else if (tx_push & tx_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_fifo_target.sv
// Bench for wb_fifo_target: directed vector table, hand-written
// corner sequences, then random traffic against a queue model.
module tb_wb_fifo_target;

  localparam int DEPTH = 8;

  logic        i_clock;
  logic        reset;
  logic [31:0] i_adr;
  logic [31:0] i_dat_w;
  logic [31:0] i_dat_r;
  logic        i_cyc;
  logic        i_stb;
  logic        i_ack;
  logic        i_we;
  logic [3:0]  i_sel;
  logic        o_tx_valid;
  logic [31:0] o_tx_data;
  logic        i_tx_ready;
  logic        i_rx_valid;
  logic [31:0] i_rx_data;
  logic        o_rx_ready;

  int errors = 0;
  int checks = 0;

  wb_fifo_target #(.ADR_WIDTH(32), .DAT_WIDTH(32), .DEPTH(DEPTH)) dut (
    .i_clock    (i_clock),
    .reset      (reset),
    .i_adr      (i_adr),
    .i_dat_w    (i_dat_w),
    .i_dat_r    (i_dat_r),
    .i_cyc      (i_cyc),
    .i_stb      (i_stb),
    .i_ack      (i_ack),
    .i_we       (i_we),
    .i_sel      (i_sel),
    .o_tx_valid (o_tx_valid),
    .o_tx_data  (o_tx_data),
    .i_tx_ready (i_tx_ready),
    .i_rx_valid (i_rx_valid),
    .i_rx_data  (i_rx_data),
    .o_rx_ready (o_rx_ready)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic        m_ovf;
  logic        m_idle;
  logic [31:0] m_dat;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int txn, input int rxn,
                                       input logic ovf);
    logic [31:0] s;
    s = 32'(txn) + (32'(rxn) << 8);
    if (txn == DEPTH) s = s + 32'h0001_0000;
    if (rxn == 0)     s = s + 32'h0002_0000;
    if (ovf)          s = s + 32'h0100_0000;
    return s;
  endfunction

  task automatic bus(input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, output logic [31:0] rdata,
                     output int lat);
    i_cyc = 1'b1; i_stb = 1'b1; i_we = we; i_adr = adr; i_dat_w = dat;
    lat = 0;
    do begin
      @(posedge i_clock); #1;
      lat++;
    end while (!i_ack && lat < 4);
    rdata = i_dat_r;
    i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0;
    @(posedge i_clock); #1;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] adr,
                        input logic [31:0] exp);
    logic [31:0] r;
    int lat;
    bus(1'b0, adr, 32'h0, r, lat);
    chk({name, "_lat"}, 32'(lat), 32'd1);
    chk(name, r, exp);
  endtask

  task automatic wr_do(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] r;
    int lat;
    bus(1'b1, adr, dat, r, lat);
    chk("wr_lat", 32'(lat), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    logic on;
    logic [1:0] off;
    logic acc;
    int txn, rxn;
    logic [31:0] rdv;

    reset = 1'b1; i_adr = '0; i_dat_w = '0; i_cyc = 0; i_stb = 0;
    i_we = 0; i_sel = 4'hF; i_tx_ready = 0; i_rx_valid = 0; i_rx_data = '0;
    #3;
    chk("rst_ack", 32'(i_ack), 32'd0);
    chk("rst_dat", i_dat_r, 32'h0);
    chk("rst_txv", 32'(o_tx_valid), 32'd0);
    chk("rst_rxr", 32'(o_rx_ready), 32'd1);
    #9 reset = 1'b0;
    @(posedge i_clock); #1;

    // Test 1: single write drained immediately
    i_tx_ready = 1; i_cyc = 1; i_stb = 1; i_we = 1;
    i_adr = 32'h0; i_dat_w = 32'hDEADBEEF;
    @(posedge i_clock); #1;
    chk("t1_ack", 32'(i_ack), 32'd1);
    chk("t1_txv", 32'(o_tx_valid), 32'd1);
    chk("t1_txd", o_tx_data, 32'hDEADBEEF);
    i_cyc = 0; i_stb = 0; i_we = 0;
    @(posedge i_clock); #1;
    chk("t1_ack_drop", 32'(i_ack), 32'd0);
    chk("t1_txv_pop", 32'(o_tx_valid), 32'd0);
    i_tx_ready = 0;
    rd_chk("t1_stat", 32'h8, 32'h0002_0000);

    // Test 2 plus register map sanity, as a vector table
    for (int i = 0; i < 9; i++)
      tbl[i] = '{1'b1, 32'h0, 32'h100 + 32'(i), 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h8, 32'h0, 1'b1, 32'h0103_0008};
    tbl[10] = '{1'b1, 32'hC, 32'h4, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h8, 32'h0, 1'b1, 32'h0003_0008};
    tbl[12] = '{1'b1, 32'hC, 32'h1, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h0};
    tbl[14] = '{1'b0, 32'hC, 32'h0, 1'b1, 32'h0};
    tbl[15] = '{1'b0, 32'hF0000008, 32'h0, 1'b1, 32'h0002_0000};
    for (int i = 0; i < 16; i++) begin
      bus(tbl[i].we, tbl[i].adr, tbl[i].dat, r, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
      if (tbl[i].chk) chk($sformatf("vec%0d_dat", i), r, tbl[i].exp);
    end

    // Test 3: RX stream push then bus pops
    i_rx_valid = 1; i_rx_data = 32'h11;
    @(posedge i_clock); #1;
    i_rx_data = 32'h22;
    @(posedge i_clock); #1;
    i_rx_valid = 0;
    rd_chk("t3_rd0", 32'h4, 32'h11);
    rd_chk("t3_rd1", 32'h4, 32'h22);
    rd_chk("t3_rd2", 32'h4, 32'h0);
    rd_chk("t3_stat", 32'h8, 32'h0002_0000);

    // Test 4a: push and pop together at count 3
    wr_do(32'h0, 32'hA1); wr_do(32'h0, 32'hA2); wr_do(32'h0, 32'hA3);
    i_cyc = 1; i_stb = 1; i_we = 1; i_adr = 32'h0; i_dat_w = 32'hA4;
    i_tx_ready = 1;
    @(posedge i_clock); #1;
    i_tx_ready = 0; i_cyc = 0; i_stb = 0; i_we = 0;
    chk("t4_head", o_tx_data, 32'hA2);
    @(posedge i_clock); #1;
    rd_chk("t4_stat", 32'h8, 32'h0002_0003);

    // Test 4b: push to full is dropped even with a same-cycle pop
    wr_do(32'hC, 32'h1);
    for (int i = 0; i < 8; i++) wr_do(32'h0, 32'hB0 + 32'(i));
    i_cyc = 1; i_stb = 1; i_we = 1; i_adr = 32'h0; i_dat_w = 32'hB8;
    i_tx_ready = 1;
    @(posedge i_clock); #1;
    i_tx_ready = 0; i_cyc = 0; i_stb = 0; i_we = 0;
    chk("t4b_head", o_tx_data, 32'hB1);
    @(posedge i_clock); #1;
    rd_chk("t4b_stat", 32'h8, 32'h0102_0007);

    // Test 5: clear beats a same-cycle RX push
    i_cyc = 1; i_stb = 1; i_we = 1; i_adr = 32'hC; i_dat_w = 32'h3;
    i_rx_valid = 1; i_rx_data = 32'h55;
    @(posedge i_clock); #1;
    i_rx_valid = 0; i_cyc = 0; i_stb = 0; i_we = 0;
    chk("t5_txv", 32'(o_tx_valid), 32'd0);
    chk("t5_rxr", 32'(o_rx_ready), 32'd1);
    @(posedge i_clock); #1;
    rd_chk("t5_stat", 32'h8, 32'h0102_0000);
    rd_chk("t5_rx", 32'h4, 32'h0);
    wr_do(32'hC, 32'h4);

    // Test 6: reset during ACK
    i_rx_valid = 1; i_rx_data = 32'h66;
    @(posedge i_clock); #1;
    i_rx_valid = 0;
    i_cyc = 1; i_stb = 1; i_we = 1; i_adr = 32'h0; i_dat_w = 32'h77;
    @(posedge i_clock); #1;
    chk("t6_ack_pre", 32'(i_ack), 32'd1);
    reset = 1;
    #1;
    chk("t6_ack", 32'(i_ack), 32'd0);
    chk("t6_txv", 32'(o_tx_valid), 32'd0);
    chk("t6_rxr", 32'(o_rx_ready), 32'd1);
    i_cyc = 0; i_stb = 0; i_we = 0;
    #2 reset = 0;
    @(posedge i_clock); #1;
    rd_chk("t6_stat", 32'h8, 32'h0002_0000);

    // Random traffic against the queue model
    tx_q.delete(); rx_q.delete();
    m_ovf = 0; m_idle = 1; m_dat = 32'h0002_0000;
    for (int n = 0; n < 600; n++) begin
      on  = ($urandom_range(0, 2) != 0);
      off = 2'($urandom_range(0, 3));
      i_cyc = on; i_stb = on;
      i_we = 1'($urandom_range(0, 1));
      i_adr = ($urandom() & 32'hFFFF_FFF3) | (32'(off) << 2);
      i_dat_w = $urandom();
      if (off == 2'd3 && $urandom_range(0, 3) != 0) i_dat_w[2:0] = 3'b0;
      i_tx_ready = ($urandom_range(0, 3) == 0);
      i_rx_valid = 1'($urandom_range(0, 1));
      i_rx_data = $urandom();

      acc = m_idle && on;
      txn = tx_q.size();
      rxn = rx_q.size();
      rdv = 32'h0;
      if (acc && !i_we && off == 2'd1 && rxn > 0) rdv = rx_q[0];
      if (acc && !i_we && off == 2'd2) rdv = stat(txn, rxn, m_ovf);
      if (acc) m_dat = rdv;
      if (acc && i_we && off == 2'd0 && txn == DEPTH) m_ovf = 1;
      if (txn > 0 && i_tx_ready) void'(tx_q.pop_front());
      if (acc && i_we && off == 2'd0 && txn < DEPTH) tx_q.push_back(i_dat_w);
      if (acc && !i_we && off == 2'd1 && rxn > 0) void'(rx_q.pop_front());
      if (i_rx_valid && rxn < DEPTH) rx_q.push_back(i_rx_data);
      if (acc && i_we && off == 2'd3) begin
        if (i_dat_w[0]) tx_q.delete();
        if (i_dat_w[1]) rx_q.delete();
        if (i_dat_w[2]) m_ovf = 0;
      end
      m_idle = !acc;

      @(posedge i_clock); #1;
      chk("rnd_ack", 32'(i_ack), 32'(!m_idle));
      chk("rnd_dat", i_dat_r, m_dat);
      chk("rnd_txv", 32'(o_tx_valid), 32'(tx_q.size() > 0));
      if (tx_q.size() > 0) chk("rnd_txd", o_tx_data, tx_q[0]);
      chk("rnd_rxr", 32'(o_rx_ready), 32'(rx_q.size() < DEPTH));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
